// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage behind the ALU.
// Accepts one word-wide load or store at a time and drives a req/ack memory port.
// Loads produce a one-cycle register-file writeback.
// Misaligned addresses fail immediately, and unanswered requests time out.
//
// Handshake: an instruction transfers on a rising edge where in_valid && in_ready.
// in_ready is high only in IDLE. Upstream holds its instruction until it transfers.
// On the memory side, mem_ack is honoured only while mem_req is high. All mem_*
// request outputs stay stable from the start of REQ until the access exits.
module load_store_unit #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        is_load,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [3:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        done,
    output logic        err,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        is_load_q;
    logic [3:0]  rd_q;
    logic [7:0]  cnt;

    // The last REQ cycle before the access is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    // Ready and stall are decoded purely from the state register.
    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // Access sequencer: every output below is a register updated only here.
    // mem_addr and mem_wdata double as the captured address and store data.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            is_load_q <= 1'b0;
            rd_q      <= 4'd0;
            cnt       <= 8'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
            wb_en     <= 1'b0;
            wb_addr   <= 4'd0;
            wb_data   <= 32'd0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        is_load_q <= is_load;
                        rd_q      <= rd;
                        mem_addr  <= addr;
                        mem_wdata <= wdata;
                        if (addr[1:0] != 2'b00) begin
                            // Misaligned: report failure without touching memory.
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            wb_en <= 1'b0;
                        end else begin
                            state   <= REQ;
                            cnt     <= 8'd0;
                            mem_req <= 1'b1;
                            mem_we  <= !is_load;
                        end
                    end
                end
                REQ: begin
                    // An ack wins over an expiring counter in the same cycle.
                    if (mem_ack) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b0;
                        if (is_load_q) begin
                            wb_en   <= 1'b1;
                            wb_addr <= rd_q;
                            wb_data <= mem_rdata;
                        end
                    end else if (cnt == CNT_LAST) begin
                        state   <= DONE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        wb_en   <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                    wb_en <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                    mem_we  <= 1'b0;
                    done    <= 1'b0;
                    err     <= 1'b0;
                    wb_en   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage placed directly downstream of the ALU. For memory-type instructions (TypeCode ≠ 00), the ALU passes B through as the effective address. This block takes that address, runs a word-wide load or store on the data-memory request/acknowledge port, and produces a one-cycle register-file writeback for loads. It also stalls the front end while an access is in flight, and flags misaligned or timed-out accesses.

## Interface
Parameters:
- TIMEOUT, 16, number of cycles spent in REQ with no mem_ack before the access is aborted (legal range 1..255)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high; sampled on clk
- in_valid  in  1  ALU output holds a memory instruction
- in_ready  out  1  unit can accept; equals (state == IDLE)
- is_load  in  1  1 = load, 0 = store
- addr  in  32  effective address (ALU result)
- wdata  in  32  store data (register value)
- rd  in  4  destination register for a load
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address
- mem_wdata  out  32  write data
- mem_rdata  in  32  read data; valid when mem_ack is high
- mem_ack  in  1  memory completes the access
- wb_en  out  1  register-file write strobe (one cycle)
- wb_addr  out  4  register index to write
- wb_data  out  32  loaded word
- done  out  1  one-cycle completion pulse (success or error)
- err  out  1  qualifies done: access failed
- busy  out  1  stall to upstream; equals !in_ready

Clock and reset: one clock; reset is synchronous and active-high.

## Operation
- States: IDLE, REQ, DONE.
- Accept:
  - Transfer occurs when in_valid && in_ready at a rising edge.
  - On transfer, register is_load, addr, wdata and rd.
- Alignment check at accept:
  - addr[1:0] != 0 → go to DONE with err=1. No memory request is issued.
  - Otherwise go to REQ and clear the timeout counter.
- REQ:
  - mem_req=1; mem_we=!is_load_q; mem_addr=addr_q; mem_wdata=wdata_q.
  - All of these are held stable until exit.
  - mem_ack is sampled only while mem_req=1. An ack seen in IDLE or DONE is ignored.
  - mem_ack=1 → capture mem_rdata if the access is a load; go to DONE with err=0.
  - No ack while counter == TIMEOUT-1 → go to DONE with err=1. mem_req drops on the same edge.
  - Otherwise increment the counter (8-bit, saturating is not needed given the range limit).
- DONE (exactly one cycle):
  - done=1.
  - wb_en=1 only when the access is a load and err=0; wb_addr=rd_q and wb_data=captured rdata.
  - Always returns to IDLE on the next edge.
- Stores never assert wb_en. Failed loads never assert wb_en.
- mem_addr and mem_wdata are don't-care while mem_req=0, but must be driven from registers (no combinational path from addr).
- in_valid while busy is ignored; upstream must hold the instruction until in_ready.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, busy=0.
  - mem_req=0, mem_we=0, done=0, err=0, wb_en=0.
  - mem_addr, mem_wdata, wb_addr and wb_data = 0.
  - Timeout counter = 0.
- Reset mid-operation: the next edge forces IDLE. mem_req and wb_en are 0 from that edge onward, and the pending access is abandoned without a done pulse.
- Accept at edge E0. REQ begins in cycle 1 with mem_req visible after E0.
- Fastest access: mem_ack high in cycle 1 → DONE in cycle 2 → in_ready=1 in cycle 3. The minimum turnaround is 3 cycles per access.
- Ack in the k-th REQ cycle → done in cycle k+1.
- Timeout: with no ack, mem_req stays high for exactly TIMEOUT cycles. The done+err pulse follows in the next cycle.
- Ack in the final (TIMEOUT-th) REQ cycle counts as success. Ack and timeout in the same cycle resolve as success.
- Misaligned: accept at E0 → done=1, err=1 in cycle 1; mem_req never asserts.
- All outputs are registered or decoded from state only. There is no combinational in→out path except in_ready/busy from state.

## Test plan
- Reset mid-REQ: start a load, assert reset in cycle 2 → mem_req=0 and in_ready=1 after that edge; no done or wb_en pulse.
- Aligned store:
  - Stimulus: addr=0x100, wdata=0xDEADBEEF, is_load=0, ack in cycle 1.
  - Response: mem_req=1, mem_we=1 and mem_addr=0x100 in cycle 1; done=1, err=0, wb_en=0 in cycle 2; in_ready=1 in cycle 3.
- Delayed load:
  - Stimulus: addr=0x204, rd=5; ack in the 3rd REQ cycle with mem_rdata=0x80000001.
  - Response: cycle 4 has wb_en=1, wb_addr=5, wb_data=0x80000001, done=1.
- Misaligned:
  - Stimulus: addr=0x102, load.
  - Response: mem_req stays 0; done=1 and err=1 in cycle 1; wb_en=0.
- Timeout boundary (TIMEOUT=4):
  - No ack → mem_req high for exactly 4 cycles, then done=1 and err=1.
  - Repeat with ack in the 4th cycle → err=0, success.
- Back-to-back and stale ack: hold in_valid high with two instructions while mem_ack is tied high → the second is accepted only when in_ready returns; an ack in IDLE has no effect.
